autosa_hls_shiftleftusz_pipe: RTL and testbench
===============================================

// Module: autosa_hls_shiftleftusz_pipe
// PURPOSE
//  Pipelined unsigned saturating left shifter: the inverse-direction partner of the right-shift/fraction unit.
//  Takes an unsigned integer plus fraction bits, and a signed shift count.
//  Positive count = left shift (fraction bits move into the integer); negative count = right shift with round-half-up.
//  Sits on the output-conversion path; valid/ready on both sides; 2-cycle latency; sticky saturation counter for debug.
// PARAMETERS
//  IN_WIDTH     32  unsigned integer input width
//  FRAC_WIDTH   35  fraction bits below data_in LSB
//  OUT_WIDTH    49  unsigned output width; IN_WIDTH < OUT_WIDTH required
//  SHIFT_WIDTH   6  signed shift count width; range -2^(SHIFT_WIDTH-1) .. 2^(SHIFT_WIDTH-1)-1
//  CNT_WIDTH    16  saturation counter width
// PORTS
//  autosa_core_clk  in   1            clock
//  autosa_core_rst  in   1            synchronous active-high reset
//  in_pvld          in   1            input valid
//  in_prdy          out  1            input ready
//  data_in          in   IN_WIDTH     unsigned integer part
//  frac_in          in   FRAC_WIDTH   fraction part; MSB weights 2^-1
//  shift_num        in   SHIFT_WIDTH  signed two's-complement shift count
//  out_pvld         out  1            output valid
//  out_prdy         in   1            output ready
//  data_out         out  OUT_WIDTH    shifted/rounded/saturated result
//  sat_out          out  1            this result saturated
//  sat_cnt_clr      in   1            clear saturation counter
//  sat_cnt          out  CNT_WIDTH    saturating count of accepted outputs with sat_out=1
// BEHAVIOUR
//  Reset (sync, active-high): out_pvld=0, data_out=0, sat_out=0, sat_cnt=0, both stage valids=0. Reset wins over every other event.
//  Handshake:
//   - Transfer occurs when pvld&prdy on a rising edge.
//   - Payload on in_* is sampled only on transfer.
//   - Outputs hold stable while out_pvld=1 and out_prdy=0.
//  Pipeline: stage S1 (compute) -> stage S2 (output register). Latency exactly 2 cycles at full throughput (1 result/cycle).
//   - s1_adv = !s2_vld | out_prdy
//   - in_prdy = !s1_vld | s1_adv  (combinational from out_prdy)
//   - No bubbles: with out_prdy held 1, back-to-back inputs give back-to-back outputs.
//   - Out-of-reset: in_prdy=1.
//  S1 arithmetic, shift_num >= 0 (s = shift_num):
//   - W = {{2^(SHIFT_WIDTH-1){0}}, data_in, frac_in} << s
//   - int = W[FRAC_WIDTH +: OUT_WIDTH]
//   - sat if any bit of W above FRAC_WIDTH+OUT_WIDTH-1 is 1
//   - Result: sat ? {OUT_WIDTH{1}} : int. Remaining fraction bits are discarded (truncate).
//  S1 arithmetic, shift_num < 0 (a = -shift_num, 1..2^(SHIFT_WIDTH-1)):
//   - q = data_in >> a (zero-extended to OUT_WIDTH)
//   - rnd = bit (a-1) of data_in, or 0 if a > IN_WIDTH
//   - Result: q + rnd. frac_in is ignored.
//   - sat=0 always (sum cannot exceed OUT_WIDTH since IN_WIDTH < OUT_WIDTH).
//   - a = 2^(SHIFT_WIDTH-1) (most-negative count) is legal: with defaults, shift 32 -> q=0, rnd=data_in[31].
//  S2 registers {data_out, sat_out} when s1_adv & s1_vld.
//  sat_cnt:
//   - +1 on each output transfer with sat_out=1; holds at all-ones (no wrap).
//   - sat_cnt_clr sets 0 next cycle. Clear and increment in the same cycle -> result is 0 (clear wins).
//  Reset mid-operation: all in-flight items are dropped; no output appears after reset deasserts until new input arrives.
// TESTING
//  1 data_in=0x1, frac_in=0x4_0000_0000 (2^-1), shift=+1 -> data_out=0x3, sat_out=0, appears 2 cycles after accept.
//  2 data_in=0xFFFF_FFFF, frac=0, shift=+17 -> data_out=0x1_FFFF_FFFE_0000, sat=0; shift=+18 -> data_out=all ones (0x1_FFFF_FFFF_FFFF), sat=1, sat_cnt=1.
//  3 data_in=0x0000_0006, shift=-2 -> 0x2 (rnd=1); data_in=0x8000_0000, shift=-32 -> 0x1; data_in=0x7FFF_FFFF, shift=-32 -> 0x0.
//  4 Stream 8 inputs with out_prdy=1 -> 8 consecutive outputs in order; toggle out_prdy 1/0 randomly -> no drop/dup, data_out stable while stalled, in_prdy=0 only when both stages full and out_prdy=0.
//  5 Force 2^CNT_WIDTH+3 saturating outputs -> sat_cnt sticks at all ones; sat_cnt_clr pulsed in the same cycle as a sat transfer -> sat_cnt=0.
//  6 Assert autosa_core_rst with both stages full -> next cycle out_pvld=0, in_prdy=1, sat_cnt=0, data_out=0.

Source files
------------

// File: rtl/autosa_hls_shiftleftusz_pipe.sv
// autosa_hls_shiftleftusz_pipe: 2-stage valid/ready unsigned saturating shifter (left with truncation, right with round-half-up)
module autosa_hls_shiftleftusz_pipe #(
  parameter int IN_WIDTH    = 32,
  parameter int FRAC_WIDTH  = 35,
  parameter int OUT_WIDTH   = 49,
  parameter int SHIFT_WIDTH = 6,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   autosa_core_clk,
  input  logic                   autosa_core_rst,
  input  logic                   in_pvld,
  output logic                   in_prdy,
  input  logic [IN_WIDTH-1:0]    data_in,
  input  logic [FRAC_WIDTH-1:0]  frac_in,
  input  logic [SHIFT_WIDTH-1:0] shift_num,
  output logic                   out_pvld,
  input  logic                   out_prdy,
  output logic [OUT_WIDTH-1:0]   data_out,
  output logic                   sat_out,
  input  logic                   sat_cnt_clr,
  output logic [CNT_WIDTH-1:0]   sat_cnt
);
  localparam int EXT = 2 ** (SHIFT_WIDTH - 1);
  localparam int WW  = EXT + IN_WIDTH + FRAC_WIDTH;
  logic                   s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
  logic                   s1_sat_q, s1_sat_d, sat_out_q, sat_out_d;
  logic [OUT_WIDTH-1:0]   s1_data_q, s1_data_d, data_out_q, data_out_d;
  logic [CNT_WIDTH-1:0]   sat_cnt_q, sat_cnt_d;
  logic [WW-1:0]          hi;
  logic [SHIFT_WIDTH-1:0] a;
  logic [IN_WIDTH-1:0]    q;
  logic                   rnd, pos_sat, res_sat, in_fire, s1_adv;
  logic [OUT_WIDTH-1:0]   res;
  always_comb begin
    hi = ({{EXT{1'b0}}, data_in, frac_in} << shift_num[SHIFT_WIDTH-2:0]) >> FRAC_WIDTH;
    pos_sat = |(hi >> OUT_WIDTH);
    a = -shift_num;
    q = data_in >> a;
    rnd = |((data_in >> (a - 1'b1)) & IN_WIDTH'(1));
    res_sat = !shift_num[SHIFT_WIDTH-1] & pos_sat;
    res = shift_num[SHIFT_WIDTH-1] ? OUT_WIDTH'(q) + OUT_WIDTH'(rnd) : (pos_sat ? '1 : hi[OUT_WIDTH-1:0]);
    s1_adv = !s2_vld_q | out_prdy;
    in_prdy = !s1_vld_q | s1_adv;
    in_fire = in_pvld & in_prdy;
    s1_vld_d = in_fire | (s1_vld_q & !s1_adv);
    s1_data_d = in_fire ? res : s1_data_q;
    s1_sat_d = in_fire ? res_sat : s1_sat_q;
    s2_vld_d = s1_adv ? s1_vld_q : s2_vld_q;
    data_out_d = (s1_adv & s1_vld_q) ? s1_data_q : data_out_q;
    sat_out_d = (s1_adv & s1_vld_q) ? s1_sat_q : sat_out_q;
    sat_cnt_d = sat_cnt_clr ? '0 :
                (s2_vld_q & out_prdy & sat_out_q & !(&sat_cnt_q)) ? sat_cnt_q + 1'b1 : sat_cnt_q;
  end
  always_ff @(posedge autosa_core_clk) begin
    if (autosa_core_rst) begin
      s1_vld_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      s1_sat_q   <= 1'b0;
      sat_out_q  <= 1'b0;
      s1_data_q  <= '0;
      data_out_q <= '0;
      sat_cnt_q  <= '0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s2_vld_q   <= s2_vld_d;
      s1_sat_q   <= s1_sat_d;
      sat_out_q  <= sat_out_d;
      s1_data_q  <= s1_data_d;
      data_out_q <= data_out_d;
      sat_cnt_q  <= sat_cnt_d;
    end
  end
  assign out_pvld = s2_vld_q;
  assign data_out = data_out_q;
  assign sat_out  = sat_out_q;
  assign sat_cnt  = sat_cnt_q;
endmodule

// File: tb/tb_autosa_hls_shiftleftusz_pipe.sv
// tb_autosa_hls_shiftleftusz_pipe: vector table, streaming scoreboard and corner sequences for the shifter pipe
module tb_autosa_hls_shiftleftusz_pipe;
  logic        clk = 1'b0;
  logic        rst, in_pvld, in_prdy, out_pvld, out_prdy, sat_out, sat_cnt_clr;
  logic [31:0] data_in;
  logic [34:0] frac_in;
  logic [5:0]  shift_num;
  logic [48:0] data_out;
  logic [15:0] sat_cnt;
  int tests = 0;
  int fails = 0;

  autosa_hls_shiftleftusz_pipe dut (
    .autosa_core_clk(clk), .autosa_core_rst(rst),
    .in_pvld(in_pvld), .in_prdy(in_prdy),
    .data_in(data_in), .frac_in(frac_in), .shift_num(shift_num),
    .out_pvld(out_pvld), .out_prdy(out_prdy),
    .data_out(data_out), .sat_out(sat_out),
    .sat_cnt_clr(sat_cnt_clr), .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [34:0] f;
    int          s;
    logic [48:0] e;
    logic        es;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] d, input logic [34:0] f, input int s);
    data_in = d;
    frac_in = f;
    shift_num = 6'(s);
  endtask

  // Value-level reference: real-number scaling by 2^s, floor for left shifts, round-half-up for right shifts
  function automatic logic [49:0] model(input logic [31:0] d, input logic [34:0] f, input int s);
    logic [127:0] v;
    if (s >= 0) begin
      v = (128'(d) << s) + (128'(f) >> (35 - s));
      return (v > 128'h1_FFFF_FFFF_FFFF) ? {1'b1, {49{1'b1}}} : {1'b0, v[48:0]};
    end
    v = (128'(d) + (128'd1 << (-s - 1))) >> (-s);
    return {1'b0, v[48:0]};
  endfunction

  task automatic wait_out(input string name);
    int n = 0;
    while (!out_pvld && n < 6) begin
      tick;
      n++;
    end
    if (!out_pvld) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: out_pvld never rose", name);
    end
  endtask

  initial begin
    logic [49:0] q[$];
    logic [49:0] exp;
    logic [48:0] prev_d;
    logic        prev_sat, stalled;
    logic [63:0] rf;
    logic [31:0] rd;
    int          rs;

    tbl[0]  = '{32'h1,        35'h4_0000_0000, 1,   49'h3,                 1'b0};
    tbl[1]  = '{32'hFFFF_FFFF, 35'h0,          17,  49'h1_FFFF_FFFE_0000,  1'b0};
    tbl[2]  = '{32'hFFFF_FFFF, 35'h0,          18,  49'h1_FFFF_FFFF_FFFF,  1'b1};
    tbl[3]  = '{32'h6,        35'h0,           -2,  49'h2,                 1'b0};
    tbl[4]  = '{32'h8000_0000, 35'h0,          -32, 49'h1,                 1'b0};
    tbl[5]  = '{32'h7FFF_FFFF, 35'h0,          -32, 49'h0,                 1'b0};
    tbl[6]  = '{32'h5,        35'h7_FFFF_FFFF, 0,   49'h5,                 1'b0};
    tbl[7]  = '{32'h1,        35'h0,           31,  49'h8000_0000,         1'b0};
    tbl[8]  = '{32'h1234_5678, 35'h7_FFFF_FFFF, -1, 49'h91A_2B3C,          1'b0};
    tbl[9]  = '{32'h2_0000,   35'h0,           31,  49'h1_0000_0000_0000,  1'b0};
    tbl[10] = '{32'h4_0000,   35'h0,           31,  49'h1_FFFF_FFFF_FFFF,  1'b1};
    tbl[11] = '{32'h0,        35'h4_0000_0000, 1,   49'h1,                 1'b0};

    rst = 1'b1; in_pvld = 1'b0; out_prdy = 1'b0; sat_cnt_clr = 1'b0;
    drive(32'h0, 35'h0, 0);
    tick; tick;
    rst = 1'b0;
    chk("rst_out_pvld", 64'(out_pvld), 64'd0);
    chk("rst_in_prdy", 64'(in_prdy), 64'd1);
    chk("rst_data_out", 64'(data_out), 64'd0);
    chk("rst_sat_out", 64'(sat_out), 64'd0);
    chk("rst_sat_cnt", 64'(sat_cnt), 64'd0);

    // exact latency: accepted at edge 1, visible after edge 2, gone after edge 3
    out_prdy = 1'b1;
    drive(32'h1, 35'h4_0000_0000, 1);
    in_pvld = 1'b1;
    tick;
    in_pvld = 1'b0;
    chk("lat_early", 64'(out_pvld), 64'd0);
    tick;
    chk("lat_valid", 64'(out_pvld), 64'd1);
    chk("lat_data", 64'(data_out), 64'h3);
    tick;
    chk("lat_drop", 64'(out_pvld), 64'd0);

    foreach (tbl[i]) begin
      drive(tbl[i].d, tbl[i].f, tbl[i].s);
      in_pvld = 1'b1;
      tick;
      in_pvld = 1'b0;
      wait_out($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_data", i), 64'(data_out), 64'(tbl[i].e));
      chk($sformatf("vec%0d_sat", i), 64'(sat_out), 64'(tbl[i].es));
      tick;
    end
    chk("sat_cnt_after_table", 64'(sat_cnt), 64'd2);
    sat_cnt_clr = 1'b1;
    tick;
    sat_cnt_clr = 1'b0;
    chk("sat_cnt_clear", 64'(sat_cnt), 64'd0);

    // clear coinciding with a saturating transfer must leave zero
    drive(32'hFFFF_FFFF, 35'h0, 31);
    in_pvld = 1'b1;
    tick;
    in_pvld = 1'b0;
    wait_out("clr_inc");
    sat_cnt_clr = 1'b1;
    tick;
    sat_cnt_clr = 1'b0;
    chk("clr_wins", 64'(sat_cnt), 64'd0);

    // back-to-back stream: 8 inputs produce 8 consecutive outputs
    for (int k = 0; k < 10; k++) begin
      in_pvld = (k < 8);
      if (k < 8) drive(32'(k * 977 + 3), 35'(k * 12345), k * 3 - 12);
      if (k >= 2) begin
        exp = model(32'((k - 2) * 977 + 3), 35'((k - 2) * 12345), (k - 2) * 3 - 12);
        chk($sformatf("stream%0d_vld", k - 2), 64'(out_pvld), 64'd1);
        chk($sformatf("stream%0d_data", k - 2), 64'(data_out), 64'(exp[48:0]));
      end
      tick;
    end
    in_pvld = 1'b0;
    chk("stream_end", 64'(out_pvld), 64'd0);

    // randomized traffic with random backpressure against a FIFO scoreboard
    stalled = 1'b0;
    prev_d = '0;
    prev_sat = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      in_pvld = $urandom_range(0, 1) == 1;
      out_prdy = $urandom_range(0, 1) == 1;
      rf = {$urandom, $urandom};
      rd = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      rs = $urandom_range(0, 63) - 32;
      drive(rd, rf[34:0], rs);
      #1;
      chk("rand_in_prdy", 64'(in_prdy), 64'(!(q.size() == 2 && !out_prdy)));
      if (stalled) begin
        chk("stall_vld", 64'(out_pvld), 64'd1);
        chk("stall_data", 64'(data_out), 64'(prev_d));
        chk("stall_sat", 64'(sat_out), 64'(prev_sat));
      end
      if (out_pvld && out_prdy) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rand_spurious: output 0x%0h with nothing outstanding", data_out);
        end else begin
          exp = q.pop_front();
          chk("rand_data", 64'(data_out), 64'(exp[48:0]));
          chk("rand_sat", 64'(sat_out), 64'(exp[49]));
        end
      end
      if (in_pvld && in_prdy) q.push_back(model(rd, rf[34:0], rs));
      stalled = out_pvld & !out_prdy;
      prev_d = data_out;
      prev_sat = sat_out;
      @(posedge clk);
      #1;
    end
    in_pvld = 1'b0;
    out_prdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (out_pvld) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL drain_spurious: output 0x%0h with nothing outstanding", data_out);
        end else begin
          exp = q.pop_front();
          chk("drain_data", 64'(data_out), 64'(exp[48:0]));
        end
      end
      tick;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);

    // sticky counter: 2^16+3 saturating transfers
    sat_cnt_clr = 1'b1;
    tick;
    sat_cnt_clr = 1'b0;
    drive(32'hFFFF_FFFF, 35'h0, 31);
    in_pvld = 1'b1;
    repeat (65536 + 3 + 2) tick;
    in_pvld = 1'b0;
    tick; tick; tick;
    chk("sat_cnt_sticky", 64'(sat_cnt), 64'hFFFF);

    // reset with both stages full
    out_prdy = 1'b0;
    in_pvld = 1'b1;
    tick; tick;
    in_pvld = 1'b0;
    chk("full_in_prdy", 64'(in_prdy), 64'd0);
    chk("full_out_pvld", 64'(out_pvld), 64'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mid_rst_out_pvld", 64'(out_pvld), 64'd0);
    chk("mid_rst_in_prdy", 64'(in_prdy), 64'd1);
    chk("mid_rst_sat_cnt", 64'(sat_cnt), 64'd0);
    chk("mid_rst_data_out", 64'(data_out), 64'd0);
    chk("mid_rst_sat_out", 64'(sat_out), 64'd0);
    out_prdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("post_rst_quiet", 64'(out_pvld), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
